// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: turns host read/write requests into PRE/ACT/RD/WR/RDA/WRA/PRA/REF
// commands with an open-row table per bank, tRCD/tRP/tCCD/tRFC spacing and periodic refresh.
module ddr_cmd_sequencer #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 14,
  parameter int TRP       = 14,
  parameter int TCCD      = 4,
  parameter int TRFC      = 260,
  parameter int TREFI     = 6240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_ap,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic [RANKS-1:0]     cs_n,
  output logic                 cke,
  output logic                 reset_n,
  output logic                 busy,
  output logic [3:0]           dbg_state
);

  localparam int BW    = BGWIDTH + BAWIDTH;
  localparam int NB    = 1 << BW;
  localparam int RAS_B = ADDRWIDTH - 1;
  localparam int CAS_B = ADDRWIDTH - 2;
  localparam int WE_B  = ADDRWIDTH - 3;
  localparam int AP_B  = 10;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WRP, S_ACT, S_WRCD, S_CAS, S_WCCD, S_PRA, S_WRPA, S_REF, S_WRFC
  } state_t;

  state_t state, state_nx;

  logic [15:0]          wait_cnt;
  logic [15:0]          ref_cnt;
  logic                 ref_pending;
  logic                 ref_wrap;
  logic [NB-1:0]        bank_open;
  logic [ADDRWIDTH-1:0] bank_row [NB];

  logic                 lat_we, lat_ap;
  logic [BGWIDTH-1:0]   lat_bg;
  logic [BAWIDTH-1:0]   lat_ba;
  logic [ADDRWIDTH-1:0] lat_row;
  logic [COLWIDTH-1:0]  lat_col;

  logic                 cur_we, cur_ap;
  logic [BGWIDTH-1:0]   cur_bg;
  logic [BAWIDTH-1:0]   cur_ba;
  logic [ADDRWIDTH-1:0] cur_row;
  logic [COLWIDTH-1:0]  cur_col;
  logic [BW-1:0]        cur_bank;

  logic                 accept, row_hit, any_open;
  logic                 pin_cmd, pin_bank, pin_act_n;
  logic [ADDRWIDTH-1:0] pin_a;
  logic                 wait_load;
  logic [15:0]          wait_ld;

  // Handshake: a request transfers on any cycle where req_valid && req_ready; the host holds
  // the request fields stable while req_valid is high and not yet accepted.
  assign req_ready = (state == S_IDLE) && !ref_pending && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign any_open  = |bank_open;
  assign ref_wrap  = (ref_cnt == 16'(TREFI - 1));

  // In IDLE the live request drives decisions; afterwards the latched copy does.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we = req_we;  cur_ap  = req_ap;  cur_bg  = req_bg;
      cur_ba = req_ba;  cur_row = req_row; cur_col = req_col;
    end else begin
      cur_we = lat_we;  cur_ap  = lat_ap;  cur_bg  = lat_bg;
      cur_ba = lat_ba;  cur_row = lat_row; cur_col = lat_col;
    end
  end

  assign cur_bank = {cur_bg, cur_ba};
  assign row_hit  = bank_open[cur_bank] && (bank_row[cur_bank] == cur_row);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (ref_pending)  state_nx = any_open ? S_PRA : S_REF;
        else if (accept)  state_nx = row_hit ? S_CAS : (bank_open[cur_bank] ? S_PRE : S_ACT);
      end
      S_PRE, S_WRP:   state_nx = (wait_cnt == 16'd0) ? S_ACT  : S_WRP;
      S_ACT, S_WRCD:  state_nx = (wait_cnt == 16'd0) ? S_CAS  : S_WRCD;
      S_CAS, S_WCCD:  state_nx = (wait_cnt == 16'd0) ? S_IDLE : S_WCCD;
      S_PRA, S_WRPA:  state_nx = (wait_cnt == 16'd0) ? S_REF  : S_WRPA;
      S_REF, S_WRFC:  state_nx = (wait_cnt == 16'd0) ? S_IDLE : S_WRFC;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Pins are decoded from the state being entered so each command appears registered.
  always_comb begin
    pin_cmd   = 1'b0;
    pin_bank  = 1'b0;
    pin_act_n = 1'b1;
    pin_a     = '0;
    pin_a[RAS_B] = 1'b1;
    pin_a[CAS_B] = 1'b1;
    pin_a[WE_B]  = 1'b1;
    wait_load = 1'b0;
    wait_ld   = 16'd0;
    unique case (state_nx)
      S_ACT: begin
        pin_cmd = 1'b1; pin_bank = 1'b1; pin_act_n = 1'b0;
        pin_a   = cur_row;
        wait_load = 1'b1; wait_ld = 16'(TRCD - 1);
      end
      S_PRE: begin
        pin_cmd = 1'b1; pin_bank = 1'b1;
        pin_a   = '0; pin_a[CAS_B] = 1'b1;
        wait_load = 1'b1; wait_ld = 16'(TRP - 1);
      end
      S_PRA: begin
        pin_cmd = 1'b1;
        pin_a   = '0; pin_a[CAS_B] = 1'b1; pin_a[AP_B] = 1'b1;
        wait_load = 1'b1; wait_ld = 16'(TRP - 1);
      end
      S_CAS: begin
        pin_cmd = 1'b1; pin_bank = 1'b1;
        pin_a   = '0; pin_a[RAS_B] = 1'b1; pin_a[WE_B] = ~cur_we; pin_a[AP_B] = cur_ap;
        pin_a[COLWIDTH-1:0] = cur_col;
        wait_load = 1'b1;
        wait_ld   = cur_ap ? 16'(TCCD + TRP - 1) : 16'(TCCD - 1);
      end
      S_REF: begin
        pin_cmd = 1'b1;
        pin_a   = '0; pin_a[WE_B] = 1'b1;
        wait_load = 1'b1; wait_ld = 16'(TRFC - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      act_n       <= 1'b1;
      A           <= '0;
      A[RAS_B]    <= 1'b1;
      A[CAS_B]    <= 1'b1;
      A[WE_B]     <= 1'b1;
      bg          <= '0;
      ba          <= '0;
      cs_n        <= '1;
      cke         <= 1'b0;
      reset_n     <= 1'b0;
      wait_cnt    <= 16'd0;
      ref_cnt     <= 16'd0;
      ref_pending <= 1'b0;
      bank_open   <= '0;
    end else begin
      state   <= state_nx;
      act_n   <= pin_act_n;
      A       <= pin_a;
      cs_n    <= {RANKS{~pin_cmd}};
      cke     <= 1'b1;
      reset_n <= 1'b1;
      if (pin_cmd) begin
        bg <= pin_bank ? cur_bg : '0;
        ba <= pin_bank ? cur_ba : '0;
      end
      if (wait_load)              wait_cnt <= wait_ld;
      else if (wait_cnt != 16'd0) wait_cnt <= wait_cnt - 16'd1;
      ref_cnt <= ref_wrap ? 16'd0 : ref_cnt + 16'd1;
      // A wrap on the REF cycle starts a new interval, so setting takes priority.
      if (ref_wrap)                ref_pending <= 1'b1;
      else if (state_nx == S_REF)  ref_pending <= 1'b0;
      unique case (state_nx)
        S_ACT:        bank_open[cur_bank] <= 1'b1;
        S_PRE:        bank_open[cur_bank] <= 1'b0;
        S_CAS:        if (cur_ap) bank_open[cur_bank] <= 1'b0;
        S_PRA, S_REF: bank_open <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_nx == S_ACT) bank_row[cur_bank] <= cur_row;
    if (accept) begin
      lat_we  <= req_we;  lat_ap  <= req_ap;  lat_bg  <= req_bg;
      lat_ba  <= req_ba;  lat_row <= req_row; lat_col <= req_col;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: directed and random requests checked every cycle against a
// timestamp-based command schedule built from the DDR4 encoding and spacing rules.
module tb_ddr_cmd_sequencer;

  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TCCD  = 4;
  localparam int TRFC  = 16;
  localparam int TREFI = 200;
  localparam int W     = 22;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_ap = 1'b0;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        act_n, cke, reset_n, busy;
  logic [16:0] A;
  logic [1:0]  bg, ba;
  logic [0:0]  cs_n;
  logic [3:0]  dbg_state;

  ddr_cmd_sequencer #(
    .RANKS(1), .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
    .TRCD(TRCD), .TRP(TRP), .TCCD(TCCD), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_ap(req_ap), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .cs_n(cs_n), .cke(cke), .reset_n(reset_n), .busy(busy), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: cycle index since reset, when the controller is next free, refresh state
  int          cyc = 0;
  bit          mrst = 1'b1;
  int          free_at = 0;
  bit          pend = 1'b0;
  int          ref_clr = -1;
  bit          m_open [16];
  logic [16:0] m_row  [16];

  // scoreboard: expected commands {act_n, A, bg, ba} with their issue cycle
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  bit           exp_bank_q[$];

  logic [W-1:0] e_pins;
  int           e_t, tt, bk;
  bit           e_cb, anyo;

  function automatic logic [16:0] cmd_a(input bit ras, input bit cas, input bit we,
                                        input bit ap, input logic [9:0] col);
    logic [16:0] a;
    a = '0;
    a[16] = ras; a[15] = cas; a[14] = we; a[10] = ap;
    a[9:0] = col;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int t, input bit an, input logic [16:0] a,
                          input logic [1:0] bgv, input logic [1:0] bav, input bit cb);
    exp_t_q.push_back(t);
    exp_q.push_back({an, a, bgv, bav});
    exp_bank_q.push_back(cb);
  endtask

  // per-cycle check of the DUT pins, then advance the model across the next edge
  always @(negedge clk) begin
    if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
      e_t    = exp_t_q.pop_front();
      e_pins = exp_q.pop_front();
      e_cb   = exp_bank_q.pop_front();
      chk("cmd_cs_n", 32'(cs_n), 32'd0);
      chk("cmd_pins", 32'({act_n, A}), 32'(e_pins[W-1:4]));
      if (e_cb) chk("cmd_bank", 32'({bg, ba}), 32'(e_pins[3:0]));
    end else begin
      chk("deselect", 32'({cs_n, act_n, A}), 32'({2'b11, cmd_a(1, 1, 1, 0, 10'd0)}));
    end
    chk("req_ready", 32'(req_ready), 32'(!rst && cyc >= free_at && !pend));
    chk("busy",      32'(busy),      32'(cyc < free_at));
    chk("cke",       32'(cke),       32'(!mrst));
    chk("reset_n",   32'(reset_n),   32'(!mrst));

    if (rst) begin
      cyc = 0; mrst = 1'b1; free_at = 0; pend = 1'b0; ref_clr = -1;
      for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
      exp_q.delete(); exp_t_q.delete(); exp_bank_q.delete();
    end else begin
      if (cyc >= free_at && pend) begin
        tt = cyc + 1;
        anyo = 1'b0;
        for (int i = 0; i < 16; i++) if (m_open[i]) anyo = 1'b1;
        if (anyo) begin
          push_cmd(tt, 1'b1, cmd_a(0, 1, 0, 1, 10'd0), 2'd0, 2'd0, 1'b0);
          tt += TRP;
        end
        push_cmd(tt, 1'b1, cmd_a(0, 0, 1, 0, 10'd0), 2'd0, 2'd0, 1'b0);
        ref_clr = tt;
        free_at = tt + TRFC;
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
      end else if (cyc >= free_at && req_valid) begin
        bk = int'({req_bg, req_ba});
        tt = cyc + 1;
        if (m_open[bk] && m_row[bk] == req_row) begin
          // row hit: column command straight away
        end else if (m_open[bk]) begin
          push_cmd(tt, 1'b1, cmd_a(0, 1, 0, 0, 10'd0), req_bg, req_ba, 1'b1);
          tt += TRP;
          push_cmd(tt, 1'b0, req_row, req_bg, req_ba, 1'b1);
          tt += TRCD;
        end else begin
          push_cmd(tt, 1'b0, req_row, req_bg, req_ba, 1'b1);
          tt += TRCD;
        end
        push_cmd(tt, 1'b1, cmd_a(1, 0, !req_we, req_ap, req_col), req_bg, req_ba, 1'b1);
        free_at = tt + TCCD + (req_ap ? TRP : 0);
        m_open[bk] = !req_ap;
        m_row[bk]  = req_row;
      end
      cyc++;
      mrst = 1'b0;
      if (cyc == ref_clr) pend = 1'b0;
      if (cyc % TREFI == 0) pend = 1'b1;
    end
  end

  // driver: present a request and hold it until the DUT takes it
  task automatic send(input bit we, input bit ap, input logic [1:0] bgv, input logic [1:0] bav,
                      input logic [16:0] row, input logic [9:0] col);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_ap = ap;
    req_bg = bgv; req_ba = bav; req_row = row; req_col = col;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // closed bank read, same-row read, row conflict write, auto-precharge write, reopen
    send(0, 0, 2'd1, 2'd2, 17'h00123, 10'h045);
    send(0, 0, 2'd1, 2'd2, 17'h00123, 10'h0a7);
    send(1, 0, 2'd1, 2'd2, 17'h00200, 10'h3c1);
    send(1, 1, 2'd1, 2'd2, 17'h00200, 10'h011);
    send(0, 0, 2'd1, 2'd2, 17'h00200, 10'h022);

    // random traffic over a few banks and rows to mix hits, misses and conflicts
    for (int n = 0; n < 40; n++) begin
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           17'($urandom_range(0, 2) * 17'h0111 + (n == 7 ? 17'h1f000 : 17'h0)),
           10'($urandom_range(0, 1023)));
      idle($urandom_range(0, 3));
    end

    // refresh while a bank is open and a request is waiting
    send(0, 0, 2'd3, 2'd1, 17'h05555, 10'h100);
    for (int k = 0; k < 2 * TREFI && (cyc % TREFI) != 0; k++) @(posedge clk);
    send(1, 0, 2'd3, 2'd1, 17'h05555, 10'h101);

    // reset in the middle of an ACT -> CAS wait
    send(1, 1, 2'd3, 2'd3, 17'h0abcd, 10'h001);
    send(0, 0, 2'd3, 2'd3, 17'h0abcd, 10'h002);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    send(0, 0, 2'd3, 2'd3, 17'h0abcd, 10'h003);

    // quiet period: one refresh with an open bank, the next with all banks closed
    idle(2 * TREFI + 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
